// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bridge: register offsets,
// status bit positions and the address region decode.
package mmio_pkg;

    localparam logic [31:0] IO_DATA_OFS   = 32'h0000_0000;
    localparam logic [31:0] IO_STATUS_OFS = 32'h0000_0004;
    localparam logic [31:0] IO_CYCLE_OFS  = 32'h0000_0008;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_UERR    = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 5;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_IODATA,
        REG_IOSTAT,
        REG_IOCYC,
        REG_UNMAPPED
    } region_e;

    function automatic region_e decode(
        input logic [31:0] adr,
        input logic [31:0] base
    );
        region_e r;
        if (adr < base)
            r = REG_RAM;
        else if (adr == base + IO_DATA_OFS)
            r = REG_IODATA;
        else if (adr == base + IO_STATUS_OFS)
            r = REG_IOSTAT;
        else if (adr == base + IO_CYCLE_OFS)
            r = REG_IOCYC;
        else
            r = REG_UNMAPPED;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; push is refused
// when full and pop when empty, both ignored during reset.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [4:0]       count,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [4:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign full  = (r_count == DEPTH_C);
    assign empty = (r_count == 5'd0);
    assign count = r_count;
    assign dout  = r_mem[r_rptr];

    assign w_push = push & ~full & ~reset;
    assign w_pop  = pop & ~empty & ~reset;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 5'd1;
            else if (w_pop && !w_push)
                r_count <= r_count - 5'd1;
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// Data-memory bridge: routes core stores/loads to RAM or to a
// small IO window (store FIFO, status register, cycle counter).
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] IO_BASE    = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] DataAdrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        ram_wren,
    output logic [31:0] ram_address,
    output logic [31:0] ram_data,
    input  logic [31:0] ram_q,
    output logic        io_valid,
    output logic [31:0] io_data,
    input  logic        io_ready
);

    region_e     w_region;
    logic        w_st_data;
    logic        w_st_stat;
    logic        w_st_cyc;
    logic        w_st_unm;
    logic        w_full;
    logic        w_empty;
    logic [4:0]  w_count;
    logic        w_push;
    logic        w_pop;
    logic        w_ovf_set;
    logic [31:0] w_status;

    logic        r_ovf;
    logic        r_uerr;
    logic [31:0] r_cycle;

    assign w_region = decode(DataAdrM, IO_BASE);

    assign ram_address = DataAdrM;
    assign ram_data    = WriteDataM;
    assign ram_wren    = MemWriteM & (w_region == REG_RAM);

    assign w_st_data = MemWriteM & (w_region == REG_IODATA);
    assign w_st_stat = MemWriteM & (w_region == REG_IOSTAT);
    assign w_st_cyc  = MemWriteM & (w_region == REG_IOCYC);
    assign w_st_unm  = MemWriteM & (w_region == REG_UNMAPPED);

    // Full is taken before any same-cycle pop, so a push into a
    // full FIFO is dropped even while the consumer is draining.
    assign w_push    = w_st_data & ~w_full;
    assign w_ovf_set = w_st_data & w_full;
    assign w_pop     = io_valid & io_ready;
    assign io_valid  = ~w_empty;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (WriteDataM),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count),
        .dout  (io_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf  <= 1'b0;
            r_uerr <= 1'b0;
        end else begin
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (w_st_stat)
                r_ovf <= 1'b0;
            if (w_st_unm)
                r_uerr <= 1'b1;
            else if (w_st_stat)
                r_uerr <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_st_cyc)
            r_cycle <= 32'd0;
        else
            r_cycle <= r_cycle + 32'd1;
    end

    always_comb begin
        w_status = 32'd0;
        w_status[ST_CNT_LSB +: ST_CNT_W] = w_count;
        w_status[ST_UERR]  = r_uerr;
        w_status[ST_OVF]   = r_ovf;
        w_status[ST_FULL]  = w_full;
        w_status[ST_EMPTY] = w_empty;
    end

    always_comb begin
        ReadDataM = 32'd0;
        unique case (w_region)
            REG_RAM:    ReadDataM = ram_q;
            REG_IOSTAT: ReadDataM = w_status;
            REG_IOCYC:  ReadDataM = r_cycle;
            default:    ReadDataM = 32'd0;
        endcase
    end

endmodule
